// File: rtl/div_unit_pkg.sv
// -----------------------------------------------------------------------------
// div_unit_pkg
//   Shared definitions for the EX-stage iterative divider.
//   - Reset, stall and divider control levels.
//   - Divider state encodings (2-bit).
// -----------------------------------------------------------------------------
package div_unit_pkg;

  // Reset and pipeline stall levels
  localparam logic RstEnable  = 1'b1;
  localparam logic RstDisable = 1'b0;
  localparam logic Stop       = 1'b1;
  localparam logic NoStop     = 1'b0;

  // Divider handshake levels
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  // Divider state machine
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
//   One restoring-division iteration (purely combinational).
//   The pair {rem, quo} is shifted left by one; the divisor is trial-subtracted
//   from the upper half. If the difference is non-negative it is kept and the
//   new quotient bit is 1, otherwise the shifted value is kept and the bit is 0.
// Ports:
//   rem      in  W  partial remainder (always < divisor)
//   quo      in  W  quotient-in-progress / remaining dividend bits
//   divisor  in  W  divisor magnitude (non-zero)
//   rem_next out W  partial remainder after this step
//   quo_next out W  quotient after this step
// -----------------------------------------------------------------------------
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic [W-1:0] quo_next
);

  // The shifted remainder needs one extra bit: rem < divisor, so after the
  // shift it is < 2*divisor and may exceed W bits.
  logic [W:0] shifted_rem;
  logic       take;

  assign shifted_rem = {rem, quo[W-1]};
  assign take        = (shifted_rem >= {1'b0, divisor});

  always_comb begin
    if (take) begin
      // True difference is < divisor, so the W-bit wrapped subtraction is exact.
      rem_next = shifted_rem[W-1:0] - divisor;
      quo_next = {quo[W-2:0], 1'b1};
    end else begin
      rem_next = shifted_rem[W-1:0];
      quo_next = {quo[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//   Iterative DATA_W-bit restoring divider for the EX stage (DIV / DIVU).
//   Produces {remainder, quotient} after DATA_W iterations, one per cycle.
//   Acts as the requesting end of the EX stall interface.
// Ports:
//   clk           in   1         clock, rising edge
//   rst           in   1         synchronous active-high reset
//   signed_div_i  in   1         1 = signed DIV, 0 = DIVU (sampled on accept)
//   opdata1_i     in   DATA_W    dividend (sampled on accept)
//   opdata2_i     in   DATA_W    divisor  (sampled on accept)
//   start_i       in   1         divide request, level, held until ready_o
//   annul_i       in   1         abandon current division (beats start_i)
//   result_o      out  2*DATA_W  {remainder, quotient}, valid with ready_o
//   ready_o       out  1         result valid (registered)
//   stallreq_o    out  1         EX stall request (combinational)
// -----------------------------------------------------------------------------
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stallreq_o
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  div_state_t            state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [DATA_W-1:0]     rem_reg, rem_next;
  logic [DATA_W-1:0]     quo_reg, quo_next;
  logic [DATA_W-1:0]     divisor_reg, divisor_next;
  logic                  signed_reg, signed_next;
  logic                  sign1_reg, sign1_next;
  logic                  sign2_reg, sign2_next;
  logic [2*DATA_W-1:0]   result_reg, result_next;
  logic                  ready_reg, ready_next;

  logic [DATA_W-1:0]     op1_abs;
  logic [DATA_W-1:0]     op2_abs;
  logic [DATA_W-1:0]     step_rem;
  logic [DATA_W-1:0]     step_quo;
  logic [DATA_W-1:0]     quo_fix;
  logic [DATA_W-1:0]     rem_fix;

  // Magnitudes of the operands; only signed divides are sign-converted.
  // |0x80000000| stays 0x80000000, which is the correct unsigned magnitude.
  assign op1_abs = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign op2_abs = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  div_step #(.W(DATA_W)) u_step (
    .rem      (rem_reg),
    .quo      (quo_reg),
    .divisor  (divisor_reg),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  // Sign fixup applied to the outcome of the final step.
  assign quo_fix = (signed_reg && (sign1_reg ^ sign2_reg)) ? -step_quo : step_quo;
  assign rem_fix = (signed_reg && sign1_reg)               ? -step_rem : step_rem;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_reg   <= DivFree;
      cnt_reg     <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      divisor_reg <= '0;
      signed_reg  <= 1'b0;
      sign1_reg   <= 1'b0;
      sign2_reg   <= 1'b0;
      result_reg  <= '0;
      ready_reg   <= DivResultNotReady;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      rem_reg     <= rem_next;
      quo_reg     <= quo_next;
      divisor_reg <= divisor_next;
      signed_reg  <= signed_next;
      sign1_reg   <= sign1_next;
      sign2_reg   <= sign2_next;
      result_reg  <= result_next;
      ready_reg   <= ready_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    rem_next     = rem_reg;
    quo_next     = quo_reg;
    divisor_next = divisor_reg;
    signed_next  = signed_reg;
    sign1_next   = sign1_reg;
    sign2_next   = sign2_reg;
    result_next  = result_reg;
    ready_next   = ready_reg;

    case (state_reg)
      DivFree: begin
        result_next = '0;
        ready_next  = DivResultNotReady;
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == '0) begin
            state_next = DivByZero;
          end else begin
            state_next   = DivOn;
            cnt_next     = '0;
            rem_next     = '0;
            quo_next     = op1_abs;   // dividend bits shift out of quo into rem
            divisor_next = op2_abs;
            signed_next  = signed_div_i;
            sign1_next   = opdata1_i[DATA_W-1];
            sign2_next   = opdata2_i[DATA_W-1];
          end
        end
      end

      DivByZero: begin
        if (annul_i) begin
          state_next  = DivFree;
          result_next = '0;
          ready_next  = DivResultNotReady;
        end else begin
          state_next  = DivEnd;
          result_next = '0;
          ready_next  = DivResultReady;
        end
      end

      DivOn: begin
        if (annul_i) begin
          state_next  = DivFree;
          result_next = '0;
          ready_next  = DivResultNotReady;
        end else begin
          rem_next = step_rem;
          quo_next = step_quo;
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == LAST_STEP) begin
            state_next  = DivEnd;
            result_next = {rem_fix, quo_fix};
            ready_next  = DivResultReady;
          end
        end
      end

      DivEnd: begin
        // Result is held while EX keeps the instruction; release on drop/annul.
        if (annul_i || start_i == DivStop) begin
          state_next  = DivFree;
          result_next = '0;
          ready_next  = DivResultNotReady;
        end
      end

      default: begin
        state_next = DivFree;
      end
    endcase
  end

  // Stall EX until the result is presented; deasserts together with ready_o.
  always_comb begin
    stallreq_o = NoStop;
    if (rst != RstEnable && start_i == DivStart && !annul_i && state_reg != DivEnd) begin
      stallreq_o = Stop;
    end
  end

  assign result_o = result_reg;
  assign ready_o  = ready_reg;

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
//   Scoreboard bench for div_unit: directed divides push their hand-computed
//   results into a queue; a monitor pops and compares on each ready_o rise.
// -----------------------------------------------------------------------------
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        stallreq;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];
  logic        ready_prev = 1'b0;

  always #5 clk = ~clk;

  div_unit #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (opdata1),
    .opdata2_i    (opdata2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready),
    .stallreq_o   (stallreq)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: compare each newly presented result against the scoreboard.
  always @(posedge clk) begin
    #1;
    if (ready && !ready_prev) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ready: got result %h expected no result", result);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("result", result, e);
        $display("txn result=%h expected=%h", result, e);
      end
    end
    ready_prev = ready;
  end

  // Issue one divide, check latency / stall length, hold for extra cycles,
  // then release start_i and check the return to idle.
  task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_res, input int exp_lat, input int hold);
    int lat;
    int stalls;
    logic [63:0] held;
    lat = 0;
    stalls = 0;
    @(negedge clk);
    signed_div = sg;
    opdata1 = a;
    opdata2 = b;
    start = 1'b1;
    exp_q.push_back(exp_res);
    for (int c = 1; c <= 100; c++) begin
      #1;
      if (stallreq) stalls++;
      @(posedge clk);
      #1;
      if (ready) begin
        lat = c;
        break;
      end
      // Operands after acceptance must not matter.
      opdata1 = $urandom;
      opdata2 = $urandom;
      signed_div = ~signed_div;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("stall_cycles", 64'(stalls), 64'(exp_lat));
    held = result;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check("hold", {result, 1'b0, ready, stallreq}, {held, 1'b0, 1'b1, 1'b0});
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    check("release", {result, 1'b0, ready}, 66'b0);
  endtask

  initial begin
    rst = 1'b1;
    signed_div = 1'b0;
    opdata1 = '0;
    opdata2 = '0;
    start = 1'b1;
    annul = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {result, ready, stallreq}, 66'b0);
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;

    // Main function
    do_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 0);
    do_div(1'b1, 32'hFFFFFFF9, 32'h2, 64'hFFFFFFFF_FFFFFFFD, 33, 0);
    do_div(1'b0, 32'hFFFFFFF9, 32'h2, 64'h00000001_7FFFFFFC, 33, 0);
    do_div(1'b1, 32'd5, 32'hFFFFFFFD, 64'h00000002_FFFFFFFF, 33, 0);
    // Divide by zero
    do_div(1'b1, 32'h12345678, 32'h0, 64'h0, 2, 1);
    // Boundaries
    do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, 0);
    do_div(1'b0, 32'hFFFFFFFF, 32'h1, 64'h00000000_FFFFFFFF, 33, 0);
    do_div(1'b1, 32'd7, 32'hFFFFFFF6, 64'h00000007_00000000, 33, 0);
    do_div(1'b0, 32'd3, 32'd10, 64'h00000003_00000000, 33, 0);

    // Annul at iteration 10, then a fresh 9 / 3
    @(negedge clk);
    signed_div = 1'b0;
    opdata1 = 32'd100;
    opdata2 = 32'd7;
    start = 1'b1;
    for (int c = 0; c < 11; c++) begin
      @(posedge clk);
      #1;
      check("no_ready_before_annul", 64'(ready), 64'd0);
    end
    @(negedge clk);
    annul = 1'b1;
    #1;
    check("stall_annul", 64'(stallreq), 64'd0);
    @(posedge clk);
    #1;
    check("annul_ready", {result, ready}, 65'b0);
    annul = 1'b0;
    do_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 0);

    // Reset at iteration 20
    @(negedge clk);
    signed_div = 1'b0;
    opdata1 = 32'd100;
    opdata2 = 32'd7;
    start = 1'b1;
    repeat (21) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("stall_in_rst", 64'(stallreq), 64'd0);
    @(posedge clk);
    #1;
    check("rst_outputs", {result, ready, stallreq}, 66'b0);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("after_rst_idle", {result, ready}, 65'b0);

    // Held in END for 5 extra cycles
    do_div(1'b0, 32'd1000, 32'd10, 64'h00000000_00000064, 33, 5);

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
